// File: rtl/sha256_pkg.sv
// SHA-256 constants, state types and round helper functions shared by the
// compression core and its round datapath.
package sha256_pkg;

  typedef logic [31:0] word_t;

  // Packed with a in the top word so a 256-bit chaining value casts directly.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } fsm_e;

  localparam int ROUNDS = 64;

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Word-wise modulo-2^32 sum used for the final chaining addition.
  function automatic state_t add_state(input state_t x, input state_t y);
    state_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working state in, round constant and
// schedule word applied, next working state out.
module sha256_round
  import sha256_pkg::*;
(
  input  state_t s_in,
  input  word_t  k,
  input  word_t  w,
  output state_t s_out
);

  word_t t1;
  word_t t2;

  assign t1 = s_in.h + bsig1(s_in.e) + ch(s_in.e, s_in.f, s_in.g) + k + w;
  assign t2 = bsig0(s_in.a) + maj(s_in.a, s_in.b, s_in.c);

  assign s_out.a = t1 + t2;
  assign s_out.b = s_in.a;
  assign s_out.c = s_in.b;
  assign s_out.d = s_in.c;
  assign s_out.e = s_in.d + t1;
  assign s_out.f = s_in.e;
  assign s_out.g = s_in.f;
  assign s_out.h = s_in.g;

endmodule

// File: rtl/sha256_compress_pipe.sv
// SHA-256 compression core: UNROLL rounds per clock over a sliding 16-word
// message schedule, with valid/ready handshakes on input and output.
module sha256_compress_pipe
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
)
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block,
  input  logic [255:0] chain_in,
  input  logic         use_iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16)
  begin : g_bad_unroll
    $error("sha256_compress_pipe: UNROLL must be 1, 2, 4, 8 or 16");
  end

  localparam int         EXT_LEN = 16 + UNROLL;
  localparam logic [6:0] T_STEP  = 7'(UNROLL);

  fsm_e       state_q, state_d;
  logic [6:0] t_q, t_d;
  state_t     h_q, h_d;
  state_t     work_q, work_d;
  word_t      w_q [0:15];
  word_t      w_d [0:15];
  state_t     digest_q, digest_d;
  logic       ready_en_q;
  logic       load;

  state_t     round_out;
  word_t      ext [0:EXT_LEN-1];
  word_t      w_slide [0:15];

  // Round chain: stage i consumes K[t+i] and the i-th window word.
  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    state_t s_in;
    state_t s_out;
    word_t  k_word;
    if (i == 0) begin : g_head
      assign s_in = work_q;
    end else begin : g_link
      assign s_in = g_round[i-1].s_out;
    end
    assign k_word = K[t_q[5:0] + 6'(i)];
    sha256_round u_round (
      .s_in  (s_in),
      .k     (k_word),
      .w     (w_q[i]),
      .s_out (s_out)
    );
  end

  assign round_out = g_round[UNROLL-1].s_out;

  // Extend the window by UNROLL words, then drop the UNROLL words just used.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      ext[j] = w_q[j];
    end
    for (int j = 16; j < EXT_LEN; j++) begin
      ext[j] = ssig1(ext[j-2]) + ext[j-7] + ssig0(ext[j-15]) + ext[j-16];
    end
    for (int j = 0; j < 16; j++) begin
      w_slide[j] = ext[j+UNROLL];
    end
  end

  assign in_ready  = (state_q == ST_IDLE && ready_en_q) ||
                     (state_q == ST_DONE && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign digest    = digest_q;

  always_comb begin
    // NOTE: every target gets a hold value first; a path that skips an
    // assignment in combinational logic would otherwise infer a latch.
    state_d  = state_q;
    t_d      = t_q;
    h_d      = h_q;
    work_d   = work_q;
    w_d      = w_q;
    digest_d = digest_q;
    load     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        load = in_valid && in_ready;
      end
      ST_ROUND: begin
        work_d = round_out;
        w_d    = w_slide;
        t_d    = t_q + T_STEP;
        if (t_q + T_STEP == 7'(ROUNDS)) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        digest_d = add_state(h_q, work_q);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          load    = in_valid;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new block may arrive from IDLE or, back-to-back, from DONE.
    if (load) begin
      state_d = ST_ROUND;
      t_d     = '0;
      h_d     = use_iv ? IV : state_t'(chain_in);
      work_d  = use_iv ? IV : state_t'(chain_in);
      for (int i = 0; i < 16; i++) begin
        w_d[i] = block[511 - 32*i -: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      h_q        <= '0;
      work_q     <= '0;
      digest_q   <= '0;
      ready_en_q <= 1'b0;
      // NOTE: the schedule window is cleared as well, so an aborted block
      // leaves no message words behind after reset.
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates make every flop sample the pre-edge
      // values, independent of statement order.
      state_q    <= state_d;
      t_q        <= t_d;
      h_q        <= h_d;
      work_q     <= work_d;
      digest_q   <= digest_d;
      ready_en_q <= 1'b1;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

endmodule

// File: doc/sha256_compress_pipe.md
# sha256_compress_pipe

Parameterised SHA-256 compression core, the successor to `compression_func`. It takes one 512-bit block and a 256-bit chaining value and returns the 256-bit post-addition state. Per-cycle round unrolling is configurable, and transfers use valid/ready handshakes in both directions. It sits between the miner's block/nonce sequencer and the double-hash controller, which chains blocks by feeding `digest` back into `chain_in`.

## Interface
- `UNROLL`, default 1: rounds evaluated per clock. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `block`/`chain_in`/`use_iv` are valid.
- `in_ready`  out  1  core can accept a block.
- `block`  in  512  message block, W0 = bits [511:480].
- `chain_in`  in  256  chaining value {a..h}, a = bits [255:224].
- `use_iv`  in  1  1 = ignore `chain_in` and use the standard SHA-256 IV.
- `out_valid`  out  1  `digest` is valid.
- `out_ready`  in  1  consumer accepts `digest`.
- `digest`  out  256  chain value plus final working state, added word-wise mod 2^32.
- `busy`  out  1  high in ROUND or FINAL.

## Operation
- The FSM has four states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch `block` into the 16-word schedule window W[0..15].
  - Latch H = (`use_iv` ? IV : `chain_in`) and set a..h = H.
  - Clear the round counter t to 0 and go to ROUND.
- ROUND:
  - Each cycle, apply UNROLL chained rounds t..t+UNROLL-1 using K[t+i] and W[0+i].
  - Slide the window by UNROLL words; new words are computed as W[j] = σ1(W[j-2]) + W[j-7] + σ0(W[j-15]) + W[j-16].
  - t += UNROLL. When t + UNROLL == 64, go to FINAL.
- FINAL: register `digest` = H + {a..h} word-wise mod 2^32, then go to DONE.
- DONE:
  - `out_valid` = 1; `digest` is held stable.
  - `in_ready` = `out_ready`.
  - On `out_ready` with no new input, go to IDLE.
  - On `out_ready && in_valid`, accept the new block in the same cycle and go directly to ROUND (back-to-back chaining).
- All arithmetic is 32-bit modulo; carries are discarded. The 7-bit counter t never exceeds 64.
- `in_valid` in ROUND or FINAL is ignored (`in_ready` = 0). The upstream block must hold its inputs.
- `out_ready` outside DONE has no effect.

## Timing
- All outputs reset to 0: `in_ready`, `out_valid`, `busy`, `digest`. The FSM resets to IDLE; t, H, a..h and W reset to 0.
- Because `in_ready` is 0 during reset, it rises in the first cycle after reset deasserts.
- Latency: if the accept edge is cycle 0, `out_valid` rises after edge 64/UNROLL + 1.
  - UNROLL=1 gives 65 cycles; UNROLL=16 gives 5 cycles.
- Throughput with `out_ready` tied high: one block every 64/UNROLL + 2 cycles.
- Asserting `reset` mid-ROUND aborts the computation immediately. No `out_valid` pulse follows; the core returns to IDLE.
- `digest` changes only on the FINAL→DONE edge and is stable whenever `out_valid` = 1.
- Critical path is UNROLL chained rounds. UNROLL > 4 is for slow clocks only.

## Structure
- `sha256_pkg` holds:
  - K[0:63] and IV constants;
  - `word_t` (logic [31:0]) and `state_t` (struct of a..h);
  - functions `ch`, `maj`, `bsig0`, `bsig1`, `ssig0`, `ssig1`.
- Sub-module `sha256_round`: purely combinational single round (state_t in, K word, W word, state_t out). Instantiated UNROLL times in a generate chain.
- The schedule window and FSM stay in the top module.

## Test plan
- "abc" (`block` = 61626380 00..00 00000018), `use_iv`=1, UNROLL=1 → `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad after exactly 65 cycles.
- Empty message (`block` = 80000000 00..00), `use_iv`=1, repeated for UNROLL = 2, 4, 8, 16 → `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; latency = 64/UNROLL + 1.
- Two-block chaining of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - block 1 sent with `use_iv`=1;
  - block 2 sent with `use_iv`=0 and `chain_in` = block-1 `digest`, accepted in the same cycle `out_ready` pops block 1;
  - → `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` → `digest` stable, `in_ready`=0, and `in_valid` pulses ignored; after release the next block is accepted normally.
- Reset mid-ROUND: assert `reset` at t=32 → all outputs read 0 immediately and no `out_valid` occurs. A fresh "abc" after reset still produces the correct digest.
- Junk `chain_in` with `use_iv`=1 → same "abc" digest; confirms `chain_in` is ignored.
